memory_receive_queue: RTL
=========================

// Module: memory_receive_queue
// PURPOSE
//  Load-return stage directly downstream of the memory issue stage. Records metadata for
//  each issued load in an in-order pending FIFO, pairs it with the memory read response,
//  then aligns and sign/zero-extends the returned word. Presents the result to writeback
//  through a registered valid/ready handshake. Backpressure is propagated to memory and issue.
// PARAMETERS
//  CORE            0               core index; used only in scan $display text
//  DATA_WIDTH      32              memory word width, in bits
//  ADDRESS_BITS    20              byte address width
//  NUM_BYTES       DATA_WIDTH/8    bytes per word
//  LOG2_NUM_BYTES  log2(NUM_BYTES) width of the offset and size fields
//  DEPTH           4               maximum outstanding loads; must be a power of 2, >=2
//  LOG2_DEPTH      log2(DEPTH)     FIFO pointer width
// PORTS
//  clock           in   1               single clock; all state updates on posedge
//  reset           in   1               asynchronous, active-high
//  load            in   1               issue: load issued this cycle (same cycle as memory_read)
//  unsigned_load   in   1               issue: 1 = zero-extend (LBU/LHU), 0 = sign-extend
//  address         in   ADDRESS_BITS    issue: byte address of the load
//  log2_bytes      in   LOG2_NUM_BYTES  issue: access size; 0 = byte, 1 = half, 2 = word
//  rd              in   5               issue: destination register tag
//  issue_ready     out  1               pending FIFO not full; load is accepted only when 1
//  memory_valid    in   1               memory: read data valid this cycle
//  memory_data     in   DATA_WIDTH      memory: full read word
//  memory_ready    out  1               memory: response accepted this cycle
//  load_valid      out  1               writeback: result valid (registered)
//  load_data       out  DATA_WIDTH      writeback: aligned, extended result
//  load_rd         out  5               writeback: destination tag
//  writeback_ready in   1               writeback: result consumed this cycle
//  outstanding     out  LOG2_DEPTH+1    current pending FIFO occupancy
//  protocol_error  out  1               sticky error flag; cleared only by reset
//  scan            in   1               enables the debug $display dump
// BEHAVIOUR
//  - Reset (asynchronous): pointers=0, outstanding=0, load_valid=0, load_data=0, load_rd=0,
//    protocol_error=0. All pending entries are discarded, including mid-operation.
//  - issue_ready  = (outstanding != DEPTH). Registered count only; no combinational path from pop.
//  - memory_ready = !load_valid | writeback_ready.
//  - Push: when load & issue_ready, write {address[LOG2_NUM_BYTES-1:0], log2_bytes,
//    unsigned_load, rd} at the write pointer.
//  - load while !issue_ready: load is dropped and protocol_error is set.
//  - Pop: when memory_valid & memory_ready & (outstanding != 0).
//  - memory_valid & memory_ready while outstanding == 0: response is discarded and
//    protocol_error is set. This case includes a same-cycle push into an empty FIFO;
//    memory latency is >= 1 cycle.
//  - memory_valid while !memory_ready: memory must hold memory_data; nothing changes here.
//  - Simultaneous push and pop: outstanding is unchanged and both pointers advance.
//    Pointers wrap modulo DEPTH.
//  - Align: shifted = memory_data >> (8*offset).
//      size 0: result = {ext(shifted[7]),  shifted[7:0]}
//      size 1: result = {ext(shifted[15]), shifted[15:0]}
//      size 2: result = shifted
//      other sizes: result = 0
//    ext = 0 if unsigned_load, else the sign bit replicated.
//  - Output register: on pop, load_valid<=1, load_data<=result, load_rd<=entry.rd.
//    Latency is exactly 1 cycle from the accepted response to load_valid.
//  - Output hold: if load_valid & !writeback_ready, the output register holds and memory_ready=0.
//  - Output clear: if load_valid & writeback_ready & no pop, load_valid<=0; data and rd hold.
//  - Misaligned half/word loads are aligned using the offset as given; no trap is raised.
//  - When scan is high, $display all ports each cycle.
// TESTING
//  - LB: load at addr 0x00003, rd=5, signed; then memory_data=0x80112233
//    -> next cycle load_valid=1, load_data=0xFFFFFF80, load_rd=5.
//  - LHU at addr 0x00002, then LH at addr 0x00000, back-to-back; data 0xBEEF8001 then 0x00008001
//    -> 0x0000BEEF, then 0xFFFF8001, returned in order.
//  - Fill: 4 loads with no response -> issue_ready=0, outstanding=4.
//    5th load -> protocol_error=1 and outstanding stays 4.
//  - Backpressure: writeback_ready=0 with load_valid=1 -> memory_ready=0 and output stable
//    for 3 cycles; raise writeback_ready -> next response is accepted the same cycle.
//  - Spurious memory_valid with outstanding=0 -> no load_valid and protocol_error=1.
//    Also: push and pop in the same cycle at outstanding=2 -> outstanding stays 2.
//  - Assert reset with 3 loads pending and load_valid=1 -> all outputs are 0 immediately;
//    a subsequent LW at addr 0x00010 returns the full word unchanged.

Source files
------------

// File: rtl/memory_receive_queue.sv
// memory_receive_queue
//
// Load-return stage that sits directly after the memory issue stage. Each issued
// load leaves its metadata (byte offset, access size, extension mode, destination
// tag) in a small in-order pending FIFO. Each memory read response is paired with
// the oldest pending entry. The returned word is aligned to the addressed byte,
// sign- or zero-extended, and registered toward writeback behind a valid/ready
// handshake. A stalled writeback stalls memory, and a full FIFO stalls issue.
//
// Ports
//   clock, reset      single clock; asynchronous active-high reset
//   load              issue: a load is issued this cycle
//   unsigned_load     issue: 1 = zero-extend, 0 = sign-extend
//   address           issue: byte address (only the in-word offset is kept)
//   log2_bytes        issue: access size (0 byte, 1 half, 2 word)
//   rd                issue: destination register tag
//   issue_ready       issue: pending FIFO has room
//   memory_valid      memory: read data valid
//   memory_data       memory: full read word
//   memory_ready      memory: response accepted this cycle
//   load_valid        writeback: registered result valid
//   load_data         writeback: aligned, extended result
//   load_rd           writeback: destination tag of the result
//   writeback_ready   writeback: result consumed this cycle
//   outstanding       current pending FIFO occupancy
//   protocol_error    sticky flag for dropped loads and unmatched responses
//   scan              debug dump enable (not used by the synthesizable logic)

module memory_receive_queue #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int NUM_BYTES      = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES),
  parameter int DEPTH          = 4,
  parameter int LOG2_DEPTH     = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      unsigned_load,
  input  logic [ADDRESS_BITS-1:0]   address,
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
  input  logic [4:0]                rd,
  output logic                      issue_ready,
  input  logic                      memory_valid,
  input  logic [DATA_WIDTH-1:0]     memory_data,
  output logic                      memory_ready,
  output logic                      load_valid,
  output logic [DATA_WIDTH-1:0]     load_data,
  output logic [4:0]                load_rd,
  input  logic                      writeback_ready,
  output logic [LOG2_DEPTH:0]       outstanding,
  output logic                      protocol_error,
  input  logic                      scan
);

  localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);

  // Pending FIFO storage, one array per metadata field.
  logic [LOG2_NUM_BYTES-1:0] offset_mem   [DEPTH];
  logic [LOG2_NUM_BYTES-1:0] size_mem     [DEPTH];
  logic                      unsigned_mem [DEPTH];
  logic [4:0]                rd_mem       [DEPTH];

  logic [LOG2_DEPTH-1:0] write_ptr;
  logic [LOG2_DEPTH-1:0] read_ptr;
  logic [LOG2_DEPTH:0]   count;

  logic push;
  logic pop;
  logic response_accepted;
  logic fifo_empty;

  logic [LOG2_NUM_BYTES-1:0] head_offset;
  logic [LOG2_NUM_BYTES-1:0] head_size;
  logic                      head_unsigned;
  logic [4:0]                head_rd;

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] result;
  logic                  byte_fill;
  logic                  half_fill;

  // The scan dump and the upper address bits play no part in the datapath.
  logic unused_inputs;
  assign unused_inputs = ^{scan, address[ADDRESS_BITS-1:LOG2_NUM_BYTES], CORE[0]};

  // Handshake decode. issue_ready looks only at the registered count, so a pop
  // in the same cycle never frees a slot combinationally.
  assign fifo_empty        = (count == '0);
  assign issue_ready       = (count != FULL_COUNT);
  assign memory_ready      = !load_valid || writeback_ready;
  assign push              = load && issue_ready;
  assign response_accepted = memory_valid && memory_ready;
  assign pop               = response_accepted && !fifo_empty;
  assign outstanding       = count;

  assign head_offset   = offset_mem[read_ptr];
  assign head_size     = size_mem[read_ptr];
  assign head_unsigned = unsigned_mem[read_ptr];
  assign head_rd       = rd_mem[read_ptr];

  // Metadata capture. Entries need no reset because the pointers and count
  // decide what is live.
  always_ff @(posedge clock) begin
    if (push) begin
      offset_mem[write_ptr]   <= address[LOG2_NUM_BYTES-1:0];
      size_mem[write_ptr]     <= log2_bytes;
      unsigned_mem[write_ptr] <= unsigned_load;
      rd_mem[write_ptr]       <= rd;
    end
  end

  // Pointers and occupancy. A push and a pop in the same cycle cancel in the
  // count while both pointers move on. Pointers wrap naturally because DEPTH
  // is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        write_ptr <= write_ptr + 1'b1;
      end
      if (pop) begin
        read_ptr <= read_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // A load issued into a full FIFO is dropped, and a response with nothing
  // pending is discarded. Both leave a sticky mark. Memory latency is at
  // least one cycle, so a response arriving in the same cycle as the push into
  // an empty FIFO also counts as unmatched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if ((load && !issue_ready) || (response_accepted && fifo_empty)) begin
      protocol_error <= 1'b1;
    end
  end

  // Alignment and extension of the returned word for the oldest pending load.
  // Misaligned half and word accesses simply use the shifted word, so the bytes
  // above the top of the word read as zero.
  always_comb begin
    shifted   = memory_data >> {head_offset, 3'b000};
    byte_fill = !head_unsigned && shifted[7];
    half_fill = !head_unsigned && shifted[15];
    result    = '0;
    case (head_size)
      LOG2_NUM_BYTES'(0): result = {{(DATA_WIDTH - 8){byte_fill}}, shifted[7:0]};
      LOG2_NUM_BYTES'(1): result = {{(DATA_WIDTH - 16){half_fill}}, shifted[15:0]};
      LOG2_NUM_BYTES'(2): result = shifted;
      default:            result = '0;
    endcase
  end

  // Writeback output register. It loads on every pop and holds while
  // writeback stalls. It drops valid after a consumed result when nothing new
  // arrives, and it keeps data and tag at their last values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_valid <= 1'b0;
      load_data  <= '0;
      load_rd    <= '0;
    end else if (pop) begin
      load_valid <= 1'b1;
      load_data  <= result;
      load_rd    <= head_rd;
    end else if (load_valid && writeback_ready) begin
      load_valid <= 1'b0;
    end
  end

endmodule
